snapreg_banked: RTL and testbench



---
 rtl/snapreg_pkg.sv | 21 ++
 rtl/snapreg_bank.sv | 47 ++++
 rtl/snapreg_banked.sv | 161 ++++++++++++++++
 tb/tb_snapreg_banked.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snapreg_pkg.sv
// Shared definitions for the banked snapshot register file: operation codes,
// controller states and the beat-count helper.
package snapreg_pkg;

    localparam logic [6:0] FN_SAVE  = 7'b0000000;
    localparam logic [6:0] FN_LOAD  = 7'b1000000;
    localparam logic [6:0] FN_CLEAR = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_LOAD,
        ST_DONE
    } sreg_state_e;

    // Beats needed to move len registers, lanes at a time (ceiling division).
    function automatic int unsigned num_beats(input int unsigned len, input int unsigned lanes);
        return (len + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/snapreg_bank.sv
// One DEPTH x XLEN snapshot bank with LANES write ports and LANES wrapping read
// ports sharing one address per lane; entry 0 is never written and reads zero.
module snapreg_bank
    import snapreg_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 32,
    parameter  int LANES = 4,
    localparam int LW    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [LANES-1:0]      we_i,
    input  logic [LANES*LW-1:0]   addr_i,
    input  logic [LANES*XLEN-1:0] wdata_i,
    output logic [LANES*XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // NOTE: the array sits under the async reset because reset must zero every
    // entry, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
        end else begin
            for (int e = 1; e < DEPTH; e++) begin
                if (clear_i) begin
                    mem_q[e] <= '0;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        if (we_i[k] && addr_i[k*LW +: LW] == LW'(e))
                            mem_q[e] <= wdata_i[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < LANES; k++)
            rdata_o[k*XLEN +: XLEN] = mem_q[addr_i[k*LW +: LW]];
    end

endmodule

// File: rtl/snapreg_banked.sv
// Multi-bank snapshot register file: request/ack controller that moves up to
// DEPTH registers, LANES per beat, between the core and a selected bank.
module snapreg_banked
    import snapreg_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 32,
    parameter  int NBANK = 2,
    parameter  int LANES = 4,
    localparam int LW    = $clog2(DEPTH),
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic [6:0]            funct7_i,
    input  logic [BW-1:0]         bank_i,
    input  logic [LW-1:0]         start_i,
    input  logic [LW:0]           len_i,
    input  logic [LANES*XLEN-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [LANES*XLEN-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  ack_o,
    output logic                  error_o
);

    sreg_state_e state_q, state_d;
    logic [BW-1:0] bank_q;
    logic [LW-1:0] start_q;
    logic [LW:0]   len_q, beat_q, beats_q;
    logic          ready_q, wready_q, rvalid_q, ack_q, error_q, error_d;

    logic accept, legal, fire, last_beat;

    assign accept    = req_i && ready_q;
    assign legal     = (funct7_i inside {FN_SAVE, FN_LOAD, FN_CLEAR}) && (32'(bank_i) < NBANK);
    assign fire      = (wready_q && wvalid_i) || (rvalid_q && rready_i);
    assign last_beat = (beat_q == beats_q - 1'b1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        error_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else if (len_i == '0 || funct7_i == FN_CLEAR) begin
                        state_d = ST_DONE;
                    end else if (funct7_i == FN_SAVE) begin
                        state_d = ST_SAVE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SAVE, ST_LOAD: if (fire && last_beat) state_d = ST_DONE;
            ST_DONE:          state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            ack_q    <= 1'b0;
            error_q  <= 1'b0;
            bank_q   <= '0;
            start_q  <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == ST_IDLE);
            wready_q <= (state_d == ST_SAVE);
            rvalid_q <= (state_d == ST_LOAD);
            ack_q    <= (state_d == ST_DONE);
            error_q  <= error_d;
            if (accept) begin
                bank_q  <= bank_i;
                start_q <= start_i;
                len_q   <= len_i;
                beats_q <= (LW+1)'(num_beats(32'(len_i), LANES));
                beat_q  <= '0;
            end else if (fire && !last_beat) begin
                beat_q  <= beat_q + 1'b1;
            end
        end
    end

    // Index math stays in LW+1 bits: bit LW flags a write past the end, and the
    // low LW bits give the wrapped read address.
    logic [LANES-1:0][LW:0] lane_off, lane_idx;
    logic [LANES-1:0]       lane_en, lane_wr;
    logic [LANES*LW-1:0]    lane_addr;

    always_comb begin
        lane_off  = '0;
        lane_idx  = '0;
        lane_en   = '0;
        lane_wr   = '0;
        lane_addr = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_off[k] = beat_q * (LW+1)'(LANES) + (LW+1)'(k);
            lane_idx[k] = {1'b0, start_q} + lane_off[k];
            lane_en[k]  = lane_off[k] < len_q;
            lane_wr[k]  = wready_q && wvalid_i && lane_en[k] && !lane_idx[k][LW];
            lane_addr[k*LW +: LW] = lane_idx[k][LW-1:0];
        end
    end

    logic [LANES*XLEN-1:0] bank_rdata [NBANK];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic             bank_clear;
        logic [LANES-1:0] bank_we;

        assign bank_clear = accept && legal && (funct7_i == FN_CLEAR) && (32'(bank_i) == b);
        assign bank_we    = (32'(bank_q) == b) ? lane_wr : '0;

        snapreg_bank #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .LANES (LANES)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (bank_clear),
            .we_i    (bank_we),
            .addr_i  (lane_addr),
            .wdata_i (wdata_i),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        rdata_o = '0;
        if (rvalid_q) begin
            for (int k = 0; k < LANES; k++)
                if (lane_en[k]) rdata_o[k*XLEN +: XLEN] = bank_rdata[bank_q][k*XLEN +: XLEN];
        end
    end

    assign ready_o  = ready_q;
    assign wready_o = wready_q;
    assign rvalid_o = rvalid_q;
    assign ack_o    = ack_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_snapreg_banked.sv
// Scoreboard bench for snapreg_banked: a bank model produces the expected LOAD
// beats and ack records when each request is driven; they are popped as the DUT responds.
module tb_snapreg_banked;
    import snapreg_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NBANK = 2;
    localparam int LANES = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  req_i;
    logic [6:0]            funct7_i;
    logic [0:0]            bank_i;
    logic [1:0]            bank3;
    logic [4:0]            start_i;
    logic [5:0]            len_i;
    logic [LANES*XLEN-1:0] wdata_i;
    logic                  wvalid_i;
    logic                  rready_i;
    logic                  ready_o, wready_o, rvalid_o, ack_o, error_o;
    logic [LANES*XLEN-1:0] rdata_o;
    logic                  ready3, wready3, rvalid3, ack3, error3;
    logic [LANES*XLEN-1:0] rdata3;

    always #5 clk_i = ~clk_i;

    snapreg_banked #(.XLEN(XLEN), .DEPTH(DEPTH), .NBANK(NBANK), .LANES(LANES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
        .funct7_i(funct7_i), .bank_i(bank_i), .start_i(start_i), .len_i(len_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .ack_o(ack_o), .error_o(error_o)
    );

    // Three-bank copy, used only to exercise an out-of-range bank number.
    snapreg_banked #(.XLEN(XLEN), .DEPTH(DEPTH), .NBANK(3), .LANES(LANES)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready3),
        .funct7_i(funct7_i), .bank_i(bank3), .start_i(start_i), .len_i(len_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready3),
        .rdata_o(rdata3), .rvalid_o(rvalid3), .rready_i(rready_i),
        .ack_o(ack3), .error_o(error3)
    );

    typedef struct {
        logic err;
        int   lat;
    } ack_exp_t;

    ack_exp_t              aq[$];
    logic [LANES*XLEN-1:0] rq[$];
    logic [XLEN-1:0]       model [NBANK][DEPTH];
    logic [XLEN-1:0]       sdata [DEPTH];
    int                    checks   = 0;
    int                    failures = 0;

    // Issue one request at a negedge, run its beats, and check data and ack.
    // gap_mask bit c-1 withholds wvalid_i / rready_i in transfer cycle c.
    task automatic run_op(input logic [6:0] fn, input int bank, input int start, input int len,
                          input int exp_lat, input int gap_mask, input bit hold_req);
        ack_exp_t              e;
        logic [LANES*XLEN-1:0] v;
        bit                    legal, done, gap;
        int                    beat, cyc, i;
        legal = (fn == FN_SAVE || fn == FN_LOAD || fn == FN_CLEAR) && bank < NBANK;
        e.err = !legal;
        e.lat = exp_lat;
        aq.push_back(e);
        if (legal && fn == FN_LOAD) begin
            for (int j = 0; j * LANES < len; j++) begin
                v = '0;
                for (int k = 0; k < LANES; k++) begin
                    i = j * LANES + k;
                    if (i < len) v[k*XLEN +: XLEN] = model[bank][(start + i) % DEPTH];
                end
                rq.push_back(v);
            end
        end
        if (legal && fn == FN_SAVE) begin
            for (int n = 0; n < len; n++)
                if (start + n < DEPTH && start + n != 0) model[bank][start + n] = sdata[n];
        end
        if (legal && fn == FN_CLEAR) begin
            for (int n = 0; n < DEPTH; n++) model[bank][n] = '0;
        end

        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: ready_o=%b expected 1", ready_o);
        end
        req_i    = 1'b1;
        funct7_i = fn;
        bank_i   = bank[0:0];
        bank3    = bank[1:0];
        start_i  = start[4:0];
        len_i    = len[5:0];
        @(posedge clk_i);
        @(negedge clk_i);
        if (hold_req) begin
            funct7_i = FN_CLEAR;
            bank_i   = 1'b0;
            bank3    = 2'd0;
            len_i    = 6'd1;
        end else begin
            req_i = 1'b0;
        end

        beat = 0;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 100) begin
            gap = (cyc <= 32) ? gap_mask[cyc-1] : 1'b0;
            if (ack_o === 1'b1) begin
                req_i    = 1'b0;
                wvalid_i = 1'b0;
                rready_i = 1'b0;
                e = aq.pop_front();
                checks++;
                if (error_o !== e.err) begin
                    failures++;
                    $display("FAIL ack_error fn=%h: error_o=%b expected %b", fn, error_o, e.err);
                end
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("FAIL ack_latency fn=%h: ack at T+%0d expected T+%0d", fn, cyc, e.lat);
                end
                done = 1'b1;
            end else begin
                wvalid_i = 1'b0;
                rready_i = 1'b0;
                if (fn == FN_SAVE) begin
                    if (gap) begin
                        wdata_i = {LANES{32'hDEAD_BEEF}};
                    end else begin
                        wvalid_i = 1'b1;
                        for (int k = 0; k < LANES; k++) begin
                            i = beat * LANES + k;
                            wdata_i[k*XLEN +: XLEN] = (i < len) ? sdata[i] : (32'hBAD0_0000 | k);
                        end
                        if (wready_o === 1'b1) beat++;
                    end
                end else if (fn == FN_LOAD) begin
                    rready_i = !gap;
                    if (rvalid_o === 1'b1) begin
                        checks++;
                        if (rq.size() == 0) begin
                            failures++;
                            $display("FAIL load_extra_beat: rdata_o=%h with no beat expected", rdata_o);
                        end else begin
                            if (rdata_o !== rq[0]) begin
                                failures++;
                                $display("FAIL load_data cyc=%0d: rdata_o=%h expected %h", cyc, rdata_o, rq[0]);
                            end
                            if (!gap) void'(rq.pop_front());
                        end
                    end
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        wvalid_i = 1'b0;
        rready_i = 1'b0;
        req_i    = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout fn=%h: no ack_o within 100 cycles", fn);
            void'(aq.pop_front());
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL load_beats_missing: %0d beats left, expected 0", rq.size());
        end
        rq.delete();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ack_pulse: ack_o=%b ready_o=%b expected 0/1", ack_o, ready_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ready_o, wready_o, rvalid_o, ack_o, error_o} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags: ready/wready/rvalid/ack/error=%b expected 10000",
                     {ready_o, wready_o, rvalid_o, ack_o, error_o});
        end
        checks++;
        if (rdata_o !== '0) begin
            failures++;
            $display("FAIL reset_rdata: rdata_o=%h expected 0", rdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || ack_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: ready_o=%b ack_o=%b expected 1/0", ready_o, ack_o);
        end
    endtask

    task automatic test_save_load();
        for (int n = 0; n < 6; n++) sdata[n] = 32'hA1 + n;
        run_op(FN_SAVE, 0, 1, 6, 3, 0, 1'b0);
        run_op(FN_LOAD, 0, 1, 6, 3, 0, 1'b0);
    endtask

    task automatic test_entry0();
        for (int n = 0; n < 4; n++) sdata[n] = 32'hB0 + n;
        run_op(FN_SAVE, 1, 0, 4, 2, 0, 1'b0);
        run_op(FN_LOAD, 1, 0, 4, 2, 0, 1'b0);
        run_op(FN_LOAD, 0, 1, 6, 3, 0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 4; n++) sdata[n] = 32'hC000_001C + n;
        run_op(FN_SAVE, 1, 28, 4, 2, 0, 1'b0);
        run_op(FN_LOAD, 1, 30, 4, 2, 0, 1'b0);
        for (int n = 0; n < 4; n++) sdata[n] = 32'hD000_0000 + n;
        run_op(FN_SAVE, 1, 30, 4, 2, 0, 1'b0);
        run_op(FN_LOAD, 1, 28, 8, 3, 0, 1'b0);
        run_op(FN_LOAD, 1, 31, 32, 9, 0, 1'b0);
    endtask

    task automatic test_errors();
        for (int n = 0; n < 6; n++) sdata[n] = 32'hEEEE_0000 + n;
        run_op(7'h7F, 0, 1, 6, 1, 0, 1'b0);
        run_op(7'h01, 1, 0, 4, 1, 0, 1'b0);
        run_op(FN_SAVE, 0, 5, 0, 1, 0, 1'b0);
        // Bank 3 is out of range for the three-bank copy; the main DUT sees len=0.
        req_i    = 1'b1;
        funct7_i = FN_LOAD;
        bank_i   = 1'b1;
        bank3    = 2'd3;
        start_i  = 5'd0;
        len_i    = 6'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        checks++;
        if (ack3 !== 1'b1 || error3 !== 1'b1) begin
            failures++;
            $display("FAIL bad_bank: ack=%b error=%b expected 1/1", ack3, error3);
        end
        checks++;
        if (ack_o !== 1'b1 || error_o !== 1'b0) begin
            failures++;
            $display("FAIL len_zero_load: ack_o=%b error_o=%b expected 1/0", ack_o, error_o);
        end
        @(negedge clk_i);
        checks++;
        if (ack3 !== 1'b0 || ready3 !== 1'b1) begin
            failures++;
            $display("FAIL bad_bank_release: ack=%b ready=%b expected 0/1", ack3, ready3);
        end
        run_op(FN_LOAD, 0, 1, 6, 3, 0, 1'b0);
    endtask

    task automatic test_clear();
        run_op(FN_CLEAR, 0, 0, 1, 1, 0, 1'b0);
        run_op(FN_LOAD, 0, 0, 32, 9, 0, 1'b0);
        run_op(FN_LOAD, 1, 0, 32, 9, 0, 1'b0);
    endtask

    task automatic test_stall();
        for (int n = 0; n < 8; n++) sdata[n] = 32'h5A00_0010 + n;
        run_op(FN_SAVE, 1, 0, 8, 5, 32'b101, 1'b0);
        run_op(FN_LOAD, 1, 0, 8, 6, 32'b111, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 5; n++) sdata[n] = 32'hF000_0040 + n;
        run_op(FN_SAVE, 0, 4, 5, 3, 0, 1'b1);
        run_op(FN_LOAD, 0, 0, 12, 4, 0, 1'b1);
        run_op(FN_LOAD, 1, 8, 4, 2, 0, 1'b0);
    endtask

    task automatic test_reset_mid_save();
        for (int n = 0; n < 8; n++) sdata[n] = 32'h7700_0000 + n;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready: ready_o=%b expected 1", ready_o);
        end
        req_i    = 1'b1;
        funct7_i = FN_SAVE;
        bank_i   = 1'b0;
        bank3    = 2'd0;
        start_i  = 5'd1;
        len_i    = 6'd8;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i    = 1'b0;
        wvalid_i = 1'b1;
        wdata_i  = {sdata[3], sdata[2], sdata[1], sdata[0]};
        @(posedge clk_i);
        @(negedge clk_i);
        wdata_i = {sdata[7], sdata[6], sdata[5], sdata[4]};
        rst_i   = 1'b1;
        #1;
        checks++;
        if (wready_o !== 1'b0 || ready_o !== 1'b1 || ack_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abort: wready_o=%b ready_o=%b ack_o=%b expected 0/1/0",
                     wready_o, ready_o, ack_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i    = 1'b0;
        wvalid_i = 1'b0;
        for (int b = 0; b < NBANK; b++)
            for (int n = 0; n < DEPTH; n++) model[b][n] = '0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ack_o !== 1'b0 || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset_no_ack c=%0d: ack_o=%b ready_o=%b expected 0/1", c, ack_o, ready_o);
            end
            @(negedge clk_i);
        end
        run_op(FN_LOAD, 0, 0, 32, 9, 0, 1'b0);
        run_op(FN_LOAD, 1, 0, 32, 9, 0, 1'b0);
    endtask

    initial begin
        rst_i    = 1'b0;
        req_i    = 1'b0;
        funct7_i = FN_SAVE;
        bank_i   = 1'b0;
        bank3    = 2'd0;
        start_i  = '0;
        len_i    = '0;
        wdata_i  = '0;
        wvalid_i = 1'b0;
        rready_i = 1'b0;
        for (int b = 0; b < NBANK; b++)
            for (int n = 0; n < DEPTH; n++) model[b][n] = '0;
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);

        test_reset();
        test_save_load();
        test_entry0();
        test_wrap();
        test_errors();
        test_clear();
        test_stall();
        test_back_to_back();
        test_reset_mid_save();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
